// File: rtl/apb2axi_bridge_pkg.sv
// Shared AXI encodings used by the APB-to-AXI bridge.
package apb2axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;
  localparam logic [2:0] AXI_SIZE_4B      = 3'b010;

  // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/apb2axi_bridge.sv
// APB slave to AXI master bridge: each APB transfer becomes one single-beat
// 32-bit AXI transaction, with pready held off until the AXI response returns.
module apb2axi_bridge
  import apb2axi_bridge_pkg::*;
#(
  parameter logic [11:0] AXI_ID = 12'h000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        pready,
  output logic [11:0] m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [11:0] m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [11:0] m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [11:0] m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]  r_state;
  logic        r_aw_acc;
  logic        r_w_acc;
  logic        r_err;
  logic [31:0] r_prdata;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;

  logic w_setup;
  logic w_aw_done;
  logic w_w_done;
  logic w_unused;

  assign w_setup   = psel & ~penable;
  assign w_aw_done = r_aw_acc | (m_awvalid & m_awready);
  assign w_w_done  = r_w_acc | (m_wvalid & m_wready);
  // Response IDs and rlast are deliberately ignored for single-beat traffic.
  assign w_unused  = ^{m_bid, m_rid, m_rlast, paddr[1:0]};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_aw_acc <= 1'b0;
      r_w_acc  <= 1'b0;
      r_err    <= 1'b0;
      r_prdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_aw_acc <= 1'b0;
          r_w_acc  <= 1'b0;
          if (w_setup) r_state <= pwrite ? S_WR_REQ : S_RD_REQ;
        end
        S_WR_REQ: begin
          r_aw_acc <= w_aw_done;
          r_w_acc  <= w_w_done;
          if (w_aw_done && w_w_done) r_state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (m_bvalid) begin
            r_err   <= resp_is_err(m_bresp);
            r_state <= S_DONE;
          end
        end
        S_RD_REQ: begin
          if (m_arready) r_state <= S_RD_RESP;
        end
        S_RD_RESP: begin
          if (m_rvalid) begin
            r_prdata <= m_rdata;
            r_err    <= resp_is_err(m_rresp);
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request payload is captured only in the setup phase and needs no reset.
  always_ff @(posedge aclk) begin
    if (r_state == S_IDLE && w_setup) begin
      r_addr  <= paddr[31:2];
      r_wdata <= pwdata;
      r_strb  <= pstrb;
    end
  end

  assign m_awvalid = (r_state == S_WR_REQ) & ~r_aw_acc;
  assign m_wvalid  = (r_state == S_WR_REQ) & ~r_w_acc;
  assign m_bready  = (r_state == S_WR_RESP);
  assign m_arvalid = (r_state == S_RD_REQ);
  assign m_rready  = (r_state == S_RD_RESP);

  assign m_awid    = AXI_ID;
  assign m_awaddr  = {r_addr, 2'b00};
  assign m_awlen   = 8'd0;
  assign m_awsize  = AXI_SIZE_4B;
  assign m_awburst = AXI_BURST_INCR;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_strb;
  assign m_wlast   = 1'b1;
  assign m_arid    = AXI_ID;
  assign m_araddr  = {r_addr, 2'b00};
  assign m_arlen   = 8'd0;
  assign m_arsize  = AXI_SIZE_4B;
  assign m_arburst = AXI_BURST_INCR;

  assign pready  = (r_state == S_DONE);
  assign pslverr = (r_state == S_DONE) & r_err;
  assign prdata  = r_prdata;

endmodule
